// File: rtl/sc_dmem_lat_pkg.sv
// Shared types and constants for the latency data memory (sc_dmem_lat).
// Address error checking is compiled in with DMEM_ERR_CHECK_EN.
package sc_dmem_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;
  localparam int NB          = DMEM_DATA_W / 8;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

  typedef struct packed {
    logic                   wr_en;
    logic [DMEM_ADDR_W-1:0] address;
    logic [NB-1:0]          byte_en;
    logic [DMEM_DATA_W-1:0] data;
  } t_dmem_req;

  typedef struct packed {
    logic [DMEM_DATA_W-1:0] data;
    logic                   err;
  } t_dmem_rsp;

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/sc_dmem_lat_rsp_fifo.sv
// Circular response FIFO with wrap-around pointers and an occupancy count.
// Head entry is presented combinationally on popData.
module sc_dmem_rsp_fifo
  import sc_dmem_pkg::*;
#(
  parameter type T     = t_dmem_rsp,
  parameter int  DEPTH = 4,
  parameter int  CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  T                 pushData,
  input  logic             pop,
  output T                 popData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 entries [DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [CNT_W-1:0] countReg;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (countReg == CNT_W'(DEPTH));
  assign empty  = (countReg == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) wrPtrReg <= nextPtr(wrPtrReg);
      if (doPop)  rdPtrReg <= nextPtr(rdPtrReg);
      case ({doPush, doPop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge Clk) begin
    if (doPush) entries[wrPtrReg] <= pushData;
  end

  assign popData = entries[rdPtrReg];
  assign count   = countReg;

endmodule

// File: rtl/sc_dmem_lat.sv
// Byte-addressed data memory with read latency, request credits and a response FIFO.
// Defining DMEM_ERR_CHECK_EN enables range/alignment error flagging.
module sc_dmem_lat
  import sc_dmem_pkg::*;
#(
  parameter int              ADDR_W         = DMEM_ADDR_W,
  parameter int              DATA_W         = DMEM_DATA_W,
  parameter int              MEM_SIZE       = 'h10000,
  parameter logic [ADDR_W-1:0] MEM_OFFSET   = 'h10000,
  parameter int              RD_LATENCY     = 2,
  parameter int              RSP_FIFO_DEPTH = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic                ReqWrEn,
  input  logic [ADDR_W-1:0]   ReqAddress,
  input  logic [DATA_W/8-1:0] ReqByteEn,
  input  logic [DATA_W-1:0]   ReqData,
  output logic                RspValid,
  input  logic                RspReady,
  output logic [DATA_W-1:0]   RspData,
  output logic                RspErr
);

  localparam int NBL   = DATA_W / 8;
  localparam int LSB   = (NBL > 1) ? $clog2(NBL) : 0;
  localparam int WORDS = MEM_SIZE / NBL;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(RSP_FIFO_DEPTH + RD_LATENCY + 1);

  genvar gi;

  if (!rd_latency_ok(RD_LATENCY) || (RSP_FIFO_DEPTH < RD_LATENCY) || ((DATA_W % 8) != 0)) begin : gBadCfg
    $error("sc_dmem_lat: unsupported RD_LATENCY / RSP_FIFO_DEPTH / DATA_W combination");
  end

  t_dmem_req         req;
  logic [ADDR_W-1:0] offsetAddr;
  logic [IDX_W-1:0]  idx;
  logic              reqErr;
  logic              reqFire;
  logic              wrFire;
  logic              rdFire;

  assign req = '{wr_en: ReqWrEn, address: ReqAddress, byte_en: ReqByteEn, data: ReqData};

  // Truncation of the offset word address gives the modulo-size wrap for free.
  assign offsetAddr = req.address - MEM_OFFSET;
  assign idx        = IDX_W'(offsetAddr >> LSB);

`ifdef DMEM_ERR_CHECK_EN
  localparam logic [ADDR_W:0]   MEM_END    = {1'b0, MEM_OFFSET} + (ADDR_W+1)'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NBL - 1);

  assign reqErr = (req.address < MEM_OFFSET)
               || ({1'b0, req.address} >= MEM_END)
               || ((req.address & ALIGN_MASK) != '0);
`else
  assign reqErr = 1'b0;
`endif

  assign reqFire = ReqValid && ReqReady;
  assign wrFire  = reqFire && req.wr_en && !reqErr;
  assign rdFire  = reqFire && !req.wr_en;

  // One narrow array per byte lane keeps byte enables a plain per-lane write enable.
  logic [DATA_W-1:0] rdWord;

  for (gi = 0; gi < NBL; gi++) begin : gLane
    logic [7:0] laneMem [WORDS];
    logic [7:0] laneRdReg;

    always_ff @(posedge Clk) begin
      if (wrFire && req.byte_en[gi]) laneMem[idx] <= req.data[gi*8 +: 8];
      if (rdFire)                    laneRdReg    <= laneMem[idx];
    end

    assign rdWord[gi*8 +: 8] = laneRdReg;
  end

  // Latency pipe: stage 0 is the registered storage read, later stages shift.
  logic [RD_LATENCY-1:0] pipeValidReg;
  logic [RD_LATENCY-1:0] pipeErrReg;
  logic [DATA_W-1:0]     pipeData [RD_LATENCY];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pipeValidReg <= '0;
      pipeErrReg   <= '0;
    end else begin
      pipeValidReg[0] <= rdFire;
      pipeErrReg[0]   <= rdFire && reqErr;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipeValidReg[k] <= pipeValidReg[k-1];
        pipeErrReg[k]   <= pipeErrReg[k-1];
      end
    end
  end

  assign pipeData[0] = rdWord;

  for (gi = 1; gi < RD_LATENCY; gi++) begin : gStage
    logic [DATA_W-1:0] dataReg;

    always_ff @(posedge Clk) begin
      dataReg <= pipeData[gi-1];
    end

    assign pipeData[gi] = dataReg;
  end

  t_dmem_rsp         pushRsp;
  t_dmem_rsp         headRsp;
  logic              pipePush;
  logic              rspPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;

  assign pipePush     = pipeValidReg[RD_LATENCY-1];
  assign pushRsp.err  = pipeErrReg[RD_LATENCY-1];
  assign pushRsp.data = pipeErrReg[RD_LATENCY-1] ? '0 : pipeData[RD_LATENCY-1];
  assign rspPop       = RspValid && RspReady;

  sc_dmem_rsp_fifo #(
    .T     (t_dmem_rsp),
    .DEPTH (RSP_FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) uRspFifo (
    .Clk      (Clk),
    .Rst      (Rst),
    .push     (pipePush),
    .pushData (pushRsp),
    .pop      (rspPop),
    .popData  (headRsp),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign RspValid = !fifoEmpty;
  assign RspData  = RspValid ? headRsp.data : '0;
  assign RspErr   = RspValid && headRsp.err;

  // Every read in flight already owns a FIFO slot, so the pipe never overruns it.
  logic [OUT_W-1:0] outstanding;

  always_comb begin
    outstanding = OUT_W'(fifoCount);
    for (int k = 0; k < RD_LATENCY; k++) begin
      outstanding = outstanding + OUT_W'(pipeValidReg[k]);
    end
  end

  assign ReqReady = !Rst && (outstanding < OUT_W'(RSP_FIFO_DEPTH));

  pushNoOverflow: assert property (@(posedge Clk) disable iff (Rst) !(pipePush && fifoFull));

endmodule

// File: tb/tb_sc_dmem_lat.sv
// Directed bench for sc_dmem_lat with a response scoreboard and a byte-lane memory model.
// Build with DMEM_ERR_CHECK_EN to exercise the address-error variant.
module tb_sc_dmem_lat;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        Clk;
  logic        Rst;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrEn;
  logic [31:0] ReqAddress;
  logic [3:0]  ReqByteEn;
  logic [31:0] ReqData;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspData;
  logic        RspErr;

  sc_dmem_lat #(
    .RD_LATENCY     (LAT),
    .RSP_FIFO_DEPTH (DEPTH)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqWrEn    (ReqWrEn),
    .ReqAddress (ReqAddress),
    .ReqByteEn  (ReqByteEn),
    .ReqData    (ReqData),
    .RspValid   (RspValid),
    .RspReady   (RspReady),
    .RspData    (RspData),
    .RspErr     (RspErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        expQ [$];
  logic [31:0] mdl [int];
  int          compared   = 0;
  int          mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic int wordIdx(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'h0001_0000;
    return int'((o >> 2) & 32'h0000_3FFF);
  endfunction

  function automatic bit isErr(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    return (a < 32'h0001_0000) || (a >= 32'h0002_0000) || (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour applied at the accept edge.
  task automatic modelAccept(input logic wr, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] data);
    int          i;
    logic [31:0] w;
    exp_t        e;
    i = wordIdx(addr);
    if (wr) begin
      if (!isErr(addr)) begin
        w = mdl.exists(i) ? mdl[i] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (be[b]) w[b*8 +: 8] = data[b*8 +: 8];
        mdl[i] = w;
      end
    end else begin
      if (isErr(addr)) begin
        e.data = 32'h0;
        e.err  = 1'b1;
      end else begin
        e.data = mdl.exists(i) ? mdl[i] : 32'h0;
        e.err  = 1'b0;
      end
      expQ.push_back(e);
    end
  endtask

  // Response monitor: samples between edges, pops the scoreboard on each handshake.
  always @(negedge Clk) begin
    exp_t e;
    #1;
    if (!Rst && RspValid && RspReady) begin
      check("rsp_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("rsp_data", RspData, e.data);
        check("rsp_err", {31'b0, RspErr}, {31'b0, e.err});
      end
      $display("rsp data=%h err=%b", RspData, RspErr);
    end
  end

  // Called aligned to a falling edge; returns aligned to the falling edge after accept.
  task automatic doReq(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] data, output int stall);
    ReqValid   = 1'b1;
    ReqWrEn    = wr;
    ReqAddress = addr;
    ReqByteEn  = be;
    ReqData    = data;
    stall      = 0;
    #1;
    while (!ReqReady && stall < 40) begin
      @(negedge Clk);
      #1;
      stall++;
    end
    check("req_accept", {31'b0, ReqReady}, 32'd1);
    if (ReqReady) begin
      @(posedge Clk);
      modelAccept(wr, addr, be, data);
    end
    $display("req %s addr=%h be=%b data=%h stall=%0d", wr ? "WR" : "RD", addr, be, data, stall);
    @(negedge Clk);
    ReqValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(negedge Clk);
      #1;
      n++;
    end
    check("drain_done", 32'(expQ.size()), 32'd0);
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          st;
    logic [31:0] held;

    Rst = 1'b1; ReqValid = 1'b0; ReqWrEn = 1'b0; ReqAddress = '0;
    ReqByteEn = '0; ReqData = '0; RspReady = 1'b1;

    repeat (2) @(negedge Clk);
    #1;
    check("rst_req_ready", {31'b0, ReqReady}, 32'd0);
    check("rst_rsp_valid", {31'b0, RspValid}, 32'd0);
    check("rst_rsp_data",  RspData, 32'd0);
    check("rst_rsp_err",   {31'b0, RspErr}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    // Preload through the write port.
    for (int i = 0; i < 8; i++)
      doReq(1'b1, 32'h0001_0000 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i) * 32'h0101_0101, st);
    doReq(1'b1, 32'h0001_0008, 4'hF, 32'h1122_3344, st);
    doReq(1'b1, 32'h0001_FFFC, 4'hF, 32'hCAFE_F00D, st);

    // Write then read next cycle, with latency measurement.
    doReq(1'b1, 32'h0001_0004, 4'hF, 32'hDEAD_BEEF, st);
    doReq(1'b0, 32'h0001_0004, 4'h0, 32'h0, st);
    #1;
    check("lat_not_early_0", {31'b0, RspValid}, 32'd0);
    for (int k = 1; k < LAT; k++) begin
      @(negedge Clk);
      #1;
      check("lat_not_early", {31'b0, RspValid}, 32'd0);
    end
    @(negedge Clk);
    #1;
    check("lat_on_time", {31'b0, RspValid}, 32'd1);
    drain();

    // Byte-lane write.
    doReq(1'b1, 32'h0001_0008, 4'b0101, 32'hAABB_CCDD, st);
    doReq(1'b0, 32'h0001_0008, 4'h0, 32'h0, st);
    drain();

    // Backpressure: fill all credits with the consumer stalled.
    RspReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      doReq(1'b0, 32'h0001_0000 + 32'(i * 4), 4'h0, 32'h0, st);
      check("bp_no_stall", 32'(st), 32'd0);
    end
    #1;
    check("bp_ready_low", {31'b0, ReqReady}, 32'd0);
    repeat (LAT) @(negedge Clk);
    #1;
    held = RspData;
    check("bp_valid_held", {31'b0, RspValid}, 32'd1);
    check("bp_head_data", RspData, expQ[0].data);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      #1;
      check("bp_head_stable", RspData, held);
      check("bp_ready_still_low", {31'b0, ReqReady}, 32'd0);
    end
    @(negedge Clk);
    RspReady = 1'b1;
    doReq(1'b0, 32'h0001_0010, 4'h0, 32'h0, st);
    check("bp_fifth_stall", 32'(st), 32'd1);
    doReq(1'b0, 32'h0001_0014, 4'h0, 32'h0, st);
    drain();

    // Streaming reads at full rate.
    for (int i = 0; i < 8; i++) begin
      doReq(1'b0, 32'h0001_0000 + 32'(i * 4), 4'h0, 32'h0, st);
      check("stream_no_stall", 32'(st), 32'd0);
    end
    drain();

    // Address error / wrap behaviour.
    doReq(1'b0, 32'h0000_FFFC, 4'h0, 32'h0, st);
    doReq(1'b1, 32'h0002_0000, 4'hF, 32'h5555_5555, st);
    doReq(1'b0, 32'h0001_0002, 4'h0, 32'h0, st);
    doReq(1'b0, 32'h0001_0000, 4'h0, 32'h0, st);
    drain();

    // Asynchronous reset with two reads in flight.
    doReq(1'b0, 32'h0001_0004, 4'h0, 32'h0, st);
    doReq(1'b0, 32'h0001_0008, 4'h0, 32'h0, st);
    #3;
    Rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", {31'b0, RspValid}, 32'd0);
    check("mid_rst_req_ready", {31'b0, ReqReady}, 32'd0);
    expQ.delete();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (6) @(negedge Clk);
    #1;
    check("post_rst_no_stale", {31'b0, RspValid}, 32'd0);
    @(negedge Clk);
    doReq(1'b0, 32'h0001_0004, 4'h0, 32'h0, st);
    drain();

    check("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
